// File: rtl/sink_list_reader.sv
// sink_list_reader: walks one neighbour's sink-ID list in word memory and streams it over valid/ready
module sink_list_reader #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_SINKS  = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] nbr_index,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] out_sink_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam logic [WORD_WIDTH-1:0] NCNT_ADDR = WORD_WIDTH'(16'h068A);
  localparam logic [WORD_WIDTH-1:0] CNT_BASE  = WORD_WIDTH'(16'h068E);
  localparam logic [WORD_WIDTH-1:0] ID_BASE   = WORD_WIDTH'(16'h0248);
  localparam logic [WORD_WIDTH-1:0] MAX_CNT   = WORD_WIDTH'(MAX_SINKS);
  typedef enum logic [2:0] {IDLE, RD_NCNT, RD_CNT, RD_ID, EMIT} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] address_q, address_d, idx_q, idx_d, k_q, k_d, cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] out_sink_id_q, out_sink_id_d, row_addr, k_inc;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, done_q, done_d, error_q, error_d;
  assign row_addr    = ID_BASE + (idx_q << 4);
  assign k_inc       = k_q + 1'b1;
  assign address     = address_q;
  assign wr_en       = 1'b0;
  assign out_sink_id = out_sink_id_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign error       = error_q;
  // next-state: each read costs an address cycle then a capture cycle; done/error are single-cycle pulses
  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    idx_d         = idx_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    out_sink_id_d = out_sink_id_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        idx_d     = nbr_index;
        address_d = NCNT_ADDR;
        state_d   = RD_NCNT;
      end
      RD_NCNT: if (idx_q >= data_in) begin
        done_d  = 1'b1;
        error_d = 1'b1;
        state_d = IDLE;
      end else begin
        address_d = CNT_BASE + (idx_q << 1);
        state_d   = RD_CNT;
      end
      RD_CNT: begin
        cnt_d = data_in;
        if (data_in > MAX_CNT || data_in == '0) begin
          done_d  = 1'b1;
          error_d = data_in != '0;
          state_d = IDLE;
        end else begin
          k_d       = '0;
          address_d = row_addr;
          state_d   = RD_ID;
        end
      end
      RD_ID: begin
        out_sink_id_d = data_in;
        out_valid_d   = 1'b1;
        out_last_d    = k_q == cnt_q - 1'b1;
        state_d       = EMIT;
      end
      EMIT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (out_last_q) begin
          done_d     = 1'b1;
          out_last_d = 1'b0;
          state_d    = IDLE;
        end else begin
          k_d       = k_inc;
          address_d = row_addr + (k_inc << 1);
          state_d   = RD_ID;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any in-flight beat without a done pulse
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      address_q     <= NCNT_ADDR;
      idx_q         <= '0;
      k_q           <= '0;
      cnt_q         <= '0;
      out_sink_id_q <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      out_sink_id_q <= out_sink_id_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end
endmodule

// File: tb/tb_sink_list_reader.sv
// tb_sink_list_reader: directed and randomized list reads checked against a memory-map reference model
module tb_sink_list_reader;
  logic clock = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [15:0] nbr_index = '0, data_in, address, out_sink_id;
  logic wr_en, out_valid, out_last, busy, done, error;
  logic [15:0] mem [0:65535];
  int tests = 0, failed = 0;
  always #5 clock = ~clock;
  assign data_in = mem[address];
  sink_list_reader dut (
    .clock(clock), .rst(rst), .start(start), .nbr_index(nbr_index), .address(address),
    .wr_en(wr_en), .data_in(data_in), .out_sink_id(out_sink_id), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .error(error)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [15:0] idx, input int stall, input bit b2b, input string tag);
    logic [15:0] ncount, cnt, a, pid;
    logic [15:0] exp_ids[$], exp_addr[$], got_ids[$], got_addr[$];
    bit got_last[$];
    bit exp_err = 0, hs, pv, pl, err_at_done = 0;
    int exp_done, done_at = -1, first_v = -1, sc = 0;
    ncount = mem[16'h068A];
    exp_addr.push_back(16'h068A);
    if (idx >= ncount) begin
      exp_err  = 1;
      exp_done = 1;
    end else begin
      a   = 16'(32'h068E + 2 * idx);
      cnt = mem[a];
      exp_addr.push_back(a);
      if (cnt > 8) begin
        exp_err  = 1;
        exp_done = 2;
      end else begin
        exp_done = 2 + int'(cnt) * (2 + stall);
        for (int k = 0; k < int'(cnt); k++) begin
          a = 16'(32'h0248 + 16 * idx + 2 * k);
          exp_addr.push_back(a);
          exp_ids.push_back(mem[a]);
        end
      end
    end
    if (b2b) check({tag, "_b2b_done"}, done, 1);
    else @(negedge clock);
    start = 1'b1;
    nbr_index = idx;
    @(posedge clock);
    #1 start = 1'b0;
    check({tag, "_e0_addr"}, address, 16'h068A);
    check({tag, "_e0_busy"}, busy, 1);
    got_addr.push_back(address);
    for (int n = 1; n <= 300 && done_at < 0; n++) begin
      pv  = out_valid;
      pid = out_sink_id;
      pl  = out_last;
      if (out_valid) begin
        out_ready = sc >= stall;
        sc++;
      end else out_ready = 1'($urandom_range(0, 1));
      hs = pv && out_ready;
      @(posedge clock);
      #1;
      if (hs) begin
        got_ids.push_back(pid);
        got_last.push_back(pl);
        sc = 0;
      end else if (pv) begin
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_id"}, out_sink_id, pid);
        check({tag, "_stall_last"}, out_last, pl);
      end
      if (out_valid && first_v < 0) first_v = n;
      if (address != got_addr[$]) got_addr.push_back(address);
      if (done) begin
        done_at = n;
        err_at_done = error;
      end
    end
    check({tag, "_done_edge"}, done_at, exp_done);
    check({tag, "_error"}, err_at_done, exp_err);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_beats"}, got_ids.size(), exp_ids.size());
    for (int i = 0; i < got_ids.size() && i < exp_ids.size(); i++) begin
      check({tag, "_beat_id"}, got_ids[i], exp_ids[i]);
      check({tag, "_beat_last"}, got_last[i], i == exp_ids.size() - 1);
    end
    check({tag, "_naddr"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) check({tag, "_addr"}, got_addr[i], exp_addr[i]);
    if (exp_ids.size() == 0) check({tag, "_no_valid"}, first_v, -1);
    else if (stall == 0) check({tag, "_first_valid"}, first_v, 3);
  endtask
  task automatic pulse_end(input string tag);
    @(posedge clock);
    #1;
    check({tag, "_done_clear"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    #12;
    check("rst_addr", address, 16'h068A);
    check("rst_flags", {wr_en, out_valid, out_last, busy, done, error}, 0);
    check("rst_id", out_sink_id, 0);
    @(negedge clock) rst = 1'b0;
    mem[16'h068A] = 3;
    mem[16'h0690] = 2;
    mem[16'h0258] = 16'h0011;
    mem[16'h025A] = 16'h0022;
    run(1, 0, 0, "nominal");
    pulse_end("nominal");
    run(1, 4, 0, "backpressure");
    pulse_end("backpressure");
    mem[16'h068A] = 2;
    run(2, 0, 0, "oor");
    pulse_end("oor");
    mem[16'h068E] = 0;
    run(0, 0, 0, "cnt0");
    pulse_end("cnt0");
    mem[16'h068E] = 9;
    run(0, 0, 0, "cnt9");
    pulse_end("cnt9");
    mem[16'h068E] = 8;
    for (int k = 0; k < 8; k++) mem[16'h0248 + 16'(2 * k)] = 16'($urandom_range(0, 65535));
    run(0, 0, 0, "cnt8");
    check("cnt8_last_addr", address, 16'h0256);
    pulse_end("cnt8");
    run(0, 0, 0, "bb1");
    run(1, 0, 1, "bb2");
    pulse_end("bb2");
    mem[16'h068E] = 3;
    @(negedge clock);
    start = 1'b1;
    nbr_index = 0;
    @(posedge clock);
    #1 start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clock);
      #1;
    end
    check("rst_mid_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_addr", address, 16'h068A);
    check("rst_mid_flags", {wr_en, out_valid, out_last, busy, done, error}, 0);
    check("rst_mid_id", out_sink_id, 0);
    repeat (3) begin
      @(posedge clock);
      #1 check("rst_mid_no_done", done, 0);
    end
    @(negedge clock) rst = 1'b0;
    run(1, 0, 0, "post_rst");
    pulse_end("post_rst");
    repeat (12) begin
      mem[16'h068A] = 16'($urandom_range(0, 6));
      for (int i = 0; i < 8; i++) begin
        mem[16'h068E + 16'(2 * i)] = 16'($urandom_range(0, 10));
        for (int k = 0; k < 8; k++) mem[16'h0248 + 16'(16 * i + 2 * k)] = 16'($urandom_range(0, 65535));
      end
      run(16'($urandom_range(0, 7)), $urandom_range(0, 2), 0, "rand");
      pulse_end("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
